// File: rtl/lenet_pkg.sv
// Shared definitions for the LeNet feature-map buffer datapath:
// default BRAM geometry, read-streamer FSM encoding and skid FIFO sizing.
package lenet_pkg;

  localparam int DEF_ADDR_WIDTH = 12;
  localparam int DEF_MEM_WIDTH  = 16;
  localparam int DEF_LEN_WIDTH  = 13;

  // The skid buffer must cover the one-cycle BRAM read latency plus one
  // word held against back-pressure.
  localparam int FIFO_DEPTH = 2;
  localparam int FIFO_CNT_W = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } rd_state_e;

endpackage

// File: rtl/bram_rd_streamer_skid_fifo2.sv
// skid_fifo2: 2-entry synchronous FIFO absorbing BRAM read data while the
// downstream stream is stalled. The caller guarantees no push when full
// (unless popping) and no pop when empty.
module skid_fifo2
  import lenet_pkg::*;
#(
  parameter int WIDTH = DEF_MEM_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  push,
  input  logic [WIDTH-1:0]      din,
  input  logic                  pop,
  output logic [WIDTH-1:0]      dout,
  output logic [FIFO_CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem [FIFO_DEPTH];
  logic             wr_ptr;
  logic             rd_ptr;

  // Storage write; entries are cleared so the stream data reads 0 after reset.
  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: only two words of storage, and the head is a visible output with a
    // defined reset value, so resetting the array is cheap and intentional.
    // NOTE: sequential state always uses non-blocking assignment so every
    // register samples pre-edge values regardless of block ordering.
    if (!reset_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else if (push) begin
      mem[wr_ptr] <= din;
    end
  end

  // Pointer and occupancy tracking; simultaneous push/pop keeps the count.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + FIFO_CNT_W'(1);
        2'b01:   count <= count - FIFO_CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  assign dout = mem[rd_ptr];

endmodule

// File: rtl/bram_rd_streamer.sv
// bram_rd_streamer: walks a BRAM address range after a start pulse, hides the
// one-cycle read latency and presents the words as a valid/ready stream.
// Reads are issued only while the 2-entry skid FIFO has a free credit, so
// back-pressure never loses or duplicates a word.
// Optional feature: define BRAM_RD_STRIDE_EN to add the i_stride port
// (address increment latched on start); otherwise the increment is 1.
module bram_rd_streamer
  import lenet_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int MEM_WIDTH  = DEF_MEM_WIDTH,
  parameter int LEN_WIDTH  = DEF_LEN_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  i_start,
  input  logic [ADDR_WIDTH-1:0] i_base_addr,
  input  logic [LEN_WIDTH-1:0]  i_len,
`ifdef BRAM_RD_STRIDE_EN
  input  logic [ADDR_WIDTH-1:0] i_stride,
`endif
  output logic                  o_idle,
  output logic                  o_done,
  output logic [ADDR_WIDTH-1:0] o_addr,
  output logic                  o_ce,
  output logic                  o_we,
  input  logic [MEM_WIDTH-1:0]  i_q,
  output logic                  o_valid,
  output logic [MEM_WIDTH-1:0]  o_data,
  input  logic                  i_ready
);

  rd_state_e state;
  rd_state_e state_nxt;

  logic [LEN_WIDTH-1:0]  len_q;
  logic [LEN_WIDTH-1:0]  issued;
  logic [LEN_WIDTH-1:0]  accepted;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [ADDR_WIDTH-1:0] stride_q;
  logic                  inflight;
  logic [FIFO_CNT_W-1:0] fifo_cnt;
  logic [FIFO_CNT_W:0]   credit_used;
  logic                  start_ok;
  logic                  pop;
  logic                  last_beat;

  assign start_ok  = (state == ST_IDLE) && i_start;
  assign pop       = o_valid && i_ready;
  assign last_beat = (state == ST_RUN) && pop &&
                     (accepted == len_q - LEN_WIDTH'(1));

  // Words that will occupy the FIFO after this edge if no new read is issued.
  assign credit_used = {1'b0, fifo_cnt}
                     + (FIFO_CNT_W+1)'(inflight)
                     - (FIFO_CNT_W+1)'(pop);

`ifdef BRAM_RD_STRIDE_EN
  // Stride is captured together with base and length.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)      stride_q <= '0;
    else if (start_ok) stride_q <= i_stride;
  end
`else
  assign stride_q = ADDR_WIDTH'(1);
`endif

  // FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  // FSM next-state: a zero-length job skips straight to DONE; the job ends on
  // the final accepted beat, never on the issue count.
  always_comb begin
    // NOTE: default first so no path through the case leaves state_nxt
    // unassigned, which would otherwise infer a latch.
    state_nxt = state;
    unique case (state)
      ST_IDLE: if (i_start)   state_nxt = (i_len == '0) ? ST_DONE : ST_RUN;
      ST_RUN:  if (last_beat) state_nxt = ST_DONE;
      ST_DONE:                state_nxt = ST_IDLE;
      default:                state_nxt = ST_IDLE;
    endcase
  end

  // FSM outputs: status flags and credit-gated read issue.
  always_comb begin
    o_idle = (state == ST_IDLE);
    o_done = (state == ST_DONE);
    o_ce   = (state == ST_RUN) && (issued < len_q) &&
             (credit_used < (FIFO_CNT_W+1)'(FIFO_DEPTH));
  end

  assign o_we   = 1'b0;
  assign o_addr = addr_q;

  // Job registers and counters; the running address wraps modulo the depth.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      len_q    <= '0;
      issued   <= '0;
      accepted <= '0;
      addr_q   <= '0;
      inflight <= 1'b0;
    end else begin
      inflight <= o_ce;
      if (start_ok) begin
        len_q    <= i_len;
        issued   <= '0;
        accepted <= '0;
        addr_q   <= i_base_addr;
      end else begin
        if (o_ce) begin
          issued <= issued + LEN_WIDTH'(1);
          addr_q <= addr_q + stride_q;
        end
        if ((state == ST_RUN) && pop) accepted <= accepted + LEN_WIDTH'(1);
      end
    end
  end

  skid_fifo2 #(
    .WIDTH (MEM_WIDTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (inflight),
    .din     (i_q),
    .pop     (pop),
    .dout    (o_data),
    .count   (fifo_cnt)
  );

  assign o_valid = (fifo_cnt != '0);

endmodule

// File: tb/tb_bram_rd_streamer.sv
// Bench for bram_rd_streamer: BRAM model preloaded with data[i]=i+0x100,
// a transaction-level model (expected address/data lists built at start) and
// a per-cycle compare process, plus literal expectations per scenario.
module tb_bram_rd_streamer;

  localparam int AW = 12;
  localparam int MW = 16;
  localparam int LW = 13;

  logic          clk = 1'b0;
  logic          reset_n = 1'b1;
  logic          i_start = 1'b0;
  logic [AW-1:0] i_base_addr = '0;
  logic [LW-1:0] i_len = '0;
`ifdef BRAM_RD_STRIDE_EN
  logic [AW-1:0] i_stride = '0;
`endif
  logic          o_idle, o_done, o_ce, o_we, o_valid;
  logic [AW-1:0] o_addr;
  logic [MW-1:0] o_data;
  logic [MW-1:0] i_q = '0;
  logic          i_ready = 1'b1;

  logic [MW-1:0] bram [1<<AW];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  bram_rd_streamer #(
    .ADDR_WIDTH (AW),
    .MEM_WIDTH  (MW),
    .LEN_WIDTH  (LW)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .i_start     (i_start),
    .i_base_addr (i_base_addr),
    .i_len       (i_len),
`ifdef BRAM_RD_STRIDE_EN
    .i_stride    (i_stride),
`endif
    .o_idle      (o_idle),
    .o_done      (o_done),
    .o_addr      (o_addr),
    .o_ce        (o_ce),
    .o_we        (o_we),
    .i_q         (i_q),
    .o_valid     (o_valid),
    .o_data      (o_data),
    .i_ready     (i_ready)
  );

  // Synchronous-read BRAM port: data appears the cycle after the enable.
  always @(posedge clk) begin
    if (o_ce) i_q <= bram[o_addr];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level model ----------------
  typedef enum {P_IDLE, P_XFER, P_DONE} phase_e;
  phase_e phase = P_IDLE;
  int exp_addr[$];
  int exp_data[$];
  int got_addr[$];
  int got_data[$];
  int m_len = 0, n_iss = 0, n_acc = 0, since = 0;
  int stride_v = 1;
  bit seen_valid = 0, prev_stall = 0, full_rate = 0;
  logic [MW-1:0] prev_data = '0;

  // Compare process: mid-cycle, outputs and next-edge inputs are both stable.
  initial begin
    logic [AW-1:0] ai;
    bit            pop;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        check("rst_idle",  o_idle,  1);
        check("rst_done",  o_done,  0);
        check("rst_ce",    o_ce,    0);
        check("rst_valid", o_valid, 0);
        check("rst_addr",  o_addr,  0);
        check("rst_data",  o_data,  0);
        phase      = P_IDLE;
        prev_stall = 0;
      end else begin
        check("idle", o_idle, phase == P_IDLE);
        check("done", o_done, phase == P_DONE);
        check("we",   o_we,   0);
        case (phase)
          P_IDLE: begin
            check("ce_idle",    o_ce,    0);
            check("valid_idle", o_valid, 0);
            if (i_start) begin
              exp_addr.delete();
              exp_data.delete();
              m_len = int'(i_len);
              for (int k = 0; k < m_len; k++) begin
                ai = i_base_addr + AW'(k * stride_v);
                exp_addr.push_back(int'(ai));
                exp_data.push_back(int'(bram[ai]));
              end
              n_iss = 0; n_acc = 0; since = 0;
              seen_valid = 0; prev_stall = 0;
              phase = (m_len == 0) ? P_DONE : P_XFER;
            end
          end
          P_XFER: begin
            since++;
            pop = o_valid && i_ready;
            if (full_rate) check("ce_rate", o_ce, since <= m_len);
            if (o_ce) begin
              check("ce_count", n_iss < m_len, 1);
              if (n_iss < m_len) check("addr", o_addr, exp_addr[n_iss]);
              got_addr.push_back(int'(o_addr));
              n_iss++;
            end
            check("credit", (n_iss - n_acc - int'(pop)) <= 2, 1);
            if (prev_stall) begin
              check("stall_valid", o_valid, 1);
              check("stall_data",  o_data,  prev_data);
            end
            if (o_valid) begin
              if (!seen_valid) begin
                check("latency", since, 3);
                seen_valid = 1;
              end
              check("data_count", n_acc < m_len, 1);
              if (n_acc < m_len) check("data", o_data, exp_data[n_acc]);
            end else if (full_rate && seen_valid) begin
              check("rate", o_valid, 1);
            end
            if (pop) begin
              got_data.push_back(int'(o_data));
              n_acc++;
              if (n_acc == m_len) begin
                check("issue_total", n_iss, m_len);
                phase = P_DONE;
              end
            end
            prev_stall = o_valid && !i_ready;
            prev_data  = o_data;
          end
          default: begin
            check("ce_done",    o_ce,    0);
            check("valid_done", o_valid, 0);
            phase = P_IDLE;
          end
        endcase
      end
    end
  end

  // One job: start pulse, optional random ready, optional start during RUN
  // (mid) or during DONE (done_start). done_cyc = cycles from start to o_done.
  task automatic run_xfer(input int base, input int len, input int strd,
                          input bit rnd, input bit mid, input bit done_start,
                          output int done_cyc);
    bit seen = 0;
    got_addr.delete();
    got_data.delete();
    done_cyc    = -1;
    i_base_addr = AW'(base);
    i_len       = LW'(len);
    stride_v    = strd;
`ifdef BRAM_RD_STRIDE_EN
    i_stride    = AW'(strd);
`endif
    full_rate = !rnd;
    i_ready   = 1'b1;
    i_start   = 1'b1;
    @(posedge clk); #2;
    i_start = 1'b0;
    for (int c = 0; c < 400; c++) begin
      if (mid && c == 3) begin
        i_start     = 1'b1;
        i_base_addr = AW'(300);
        i_len       = LW'(2);
`ifdef BRAM_RD_STRIDE_EN
        i_stride    = AW'(7);
`endif
      end
      if (mid && c == 4) i_start = 1'b0;
      if (rnd) i_ready = 1'($urandom_range(0, 1));
      if (o_done) begin
        seen     = 1;
        done_cyc = c;
        break;
      end
      @(posedge clk); #2;
    end
    check("done_seen", seen, 1);
    if (done_start) i_start = 1'b1;
    @(posedge clk); #2;
    i_start = 1'b0;
    i_ready = 1'b1;
  endtask

  initial begin
    int dc;
    int wrap_a[4];
    for (int i = 0; i < (1 << AW); i++) bram[i] = MW'(i + 'h100);
    #1 reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #2 reset_n = 1'b1;
    @(posedge clk); #2;

    // Basic stream, ready held high.
    run_xfer(10, 5, 1, 0, 0, 0, dc);
    check("t1_done_cycle", dc, 7);
    check("t1_count", got_data.size(), 5);
    for (int k = 0; k < got_data.size(); k++) check("t1_word", got_data[k], 'h10A + k);

    // Same job under random back-pressure.
    run_xfer(10, 5, 1, 1, 0, 0, dc);
    check("t2_count", got_data.size(), 5);
    for (int k = 0; k < got_data.size(); k++) check("t2_word", got_data[k], 'h10A + k);

    // Address wrap-around at the top of the buffer.
    wrap_a = '{4094, 4095, 0, 1};
    run_xfer(4094, 4, 1, 0, 0, 0, dc);
    check("t3_done_cycle", dc, 6);
    check("t3_count", got_addr.size(), 4);
    for (int k = 0; k < got_addr.size() && k < 4; k++) check("t3_addr", got_addr[k], wrap_a[k]);
    check("t3_word0", got_data.size() > 0 ? got_data[0] : -1, 'h10FE);

    // Zero-length job; also a start pulse during DONE must be ignored.
    run_xfer(20, 0, 1, 0, 0, 1, dc);
    check("t4_done_cycle", dc, 0);
    check("t4_no_ce",    got_addr.size(), 0);
    check("t4_no_valid", got_data.size(), 0);
    repeat (3) @(posedge clk);
    #2 check("t4_still_idle", o_idle, 1);

    // Start pulse during RUN is ignored.
    run_xfer(100, 6, 1, 0, 1, 0, dc);
    check("t5_count", got_data.size(), 6);
    for (int k = 0; k < got_data.size(); k++) check("t5_word", got_data[k], 'h164 + k);

    // Asynchronous reset at beat 3 of an 8-word job.
    got_addr.delete();
    got_data.delete();
    i_base_addr = AW'(50);
    i_len       = LW'(8);
    stride_v    = 1;
`ifdef BRAM_RD_STRIDE_EN
    i_stride    = AW'(1);
`endif
    full_rate = 1;
    i_start   = 1'b1;
    @(posedge clk); #2;
    i_start = 1'b0;
    for (int c = 0; c < 50 && n_acc < 3; c++) begin
      @(posedge clk); #2;
    end
    check("t6_reached_beat3", n_acc, 3);
    reset_n = 1'b0;
    #1;
    check("t6_async_idle",  o_idle,  1);
    check("t6_async_ce",    o_ce,    0);
    check("t6_async_valid", o_valid, 0);
    check("t6_async_data",  o_data,  0);
    check("t6_async_addr",  o_addr,  0);
    check("t6_async_done",  o_done,  0);
    repeat (2) @(posedge clk);
    #2 reset_n = 1'b1;
    @(posedge clk); #2;
    run_xfer(0, 2, 1, 0, 0, 0, dc);
    check("t6_count", got_data.size(), 2);
    for (int k = 0; k < got_data.size(); k++) check("t6_word", got_data[k], 'h100 + k);

`ifdef BRAM_RD_STRIDE_EN
    // Strided walk, with an ignored start pulse during RUN.
    run_xfer(0, 4, 3, 0, 1, 0, dc);
    check("t7_count", got_addr.size(), 4);
    for (int k = 0; k < got_addr.size(); k++) check("t7_addr", got_addr[k], 3 * k);
    for (int k = 0; k < got_data.size(); k++) check("t7_word", got_data[k], 'h100 + 3 * k);
    // Stride 0 re-reads the base address.
    run_xfer(7, 3, 0, 1, 0, 0, dc);
    for (int k = 0; k < got_data.size(); k++) check("t8_word", got_data[k], 'h107);
`endif

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Hard stop in case the bench itself stalls.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/bram_rd_streamer.md
# bram_rd_streamer

Read-side sequencer for the on-chip dual-port BRAM feature-map buffers. On a start command it walks a contiguous (optionally strided) address range on one BRAM port, absorbs the 1-cycle BRAM read latency, and presents the words as a valid/ready stream to the downstream convolution/pooling datapath. A credit-controlled 2-entry skid FIFO handles back-pressure. The block sustains 1 word/cycle while `i_ready` is held high.

## Interface
- `ADDR_WIDTH`, 12: BRAM address width, log2 of buffer depth.
- `MEM_WIDTH`, 16: BRAM word width, equal to the stream data width.
- `LEN_WIDTH`, 13: width of the transfer-length field, so up to 2^LEN_WIDTH−1 words.

Ports. One clock; reset is asynchronous and active-low.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `i_start`  in  1  start pulse; sampled only in IDLE.
- `i_base_addr`  in  ADDR_WIDTH  first address; latched on start.
- `i_len`  in  LEN_WIDTH  number of words; latched on start.
- `i_stride`  in  ADDR_WIDTH  address increment; present only with `BRAM_RD_STRIDE_EN`.
- `o_idle`  out  1  high in IDLE.
- `o_done`  out  1  one-cycle pulse at the end of a transfer.
- `o_addr`  out  ADDR_WIDTH  BRAM port address.
- `o_ce`  out  1  BRAM port enable.
- `o_we`  out  1  BRAM write enable; tied to 0.
- `i_q`  in  MEM_WIDTH  BRAM read data, valid the cycle after `o_ce`.
- `o_valid`  out  1  stream data valid.
- `o_data`  out  MEM_WIDTH  stream data; this is the FIFO head.
- `i_ready`  in  1  downstream ready.

## Operation
- FSM states: IDLE → RUN → DONE → IDLE.
  - IDLE with `i_start`: latch base, len, and stride; clear the counters; go to RUN, or go directly to DONE if len==0.
  - RUN: stay until the final handshake (`o_valid & i_ready` on beat len−1), then go to DONE.
  - DONE: lasts one cycle; `o_done`=1, then return to IDLE.
- `i_start` is ignored outside IDLE.
- Read issue in RUN:
  - `o_ce`=1 when issued<len and (fifo_cnt + inflight − pop) < 2.
  - pop = `o_valid & i_ready`.
  - inflight is 1 if a read was issued in the previous cycle.
- Addressing:
  - `o_addr` = base + issued×stride, truncated to ADDR_WIDTH, so it wraps modulo 2^ADDR_WIDTH.
  - stride is 1 without the macro.
- Capture: `i_q` is written into the FIFO in the cycle after an issue. The FIFO never overflows, by the credit rule.
- FIFO:
  - 2 entries; `o_valid` = fifo_cnt≠0.
  - Data order equals address order.
  - Push and pop in the same cycle leaves the count unchanged.
- Counters:
  - issued and accepted are both LEN_WIDTH bits.
  - The transfer ends on accepted==len, never on the issue count.
- `o_we` is constant 0, and `o_ce` is 0 outside RUN.

## Timing
- Reset values: state=IDLE, `o_idle`=1, `o_done`=0, `o_ce`=0, `o_valid`=0, `o_addr`=0, `o_data`=0. Counters and FIFO are empty.
- Start sampled at edge E0:
  - first `o_ce` is high in the cycle after E0 (addr=base).
  - `i_q` is valid after E1.
  - first `o_valid` is high after E2.
  - Latency from start to first valid is 2 cycles.
- With `i_ready` held high: one beat per cycle. The last beat is accepted at edge En; `o_done` is high for the following cycle and `o_idle` rises one cycle later.
- Back-pressure:
  - `o_data`/`o_valid` hold stable while `o_valid & !i_ready`.
  - At most 2 words are buffered and issue stalls.
  - When `i_ready` returns, throughput resumes with no lost or duplicated words.
- Asynchronous reset mid-transfer: all state returns to reset values immediately. Buffered and in-flight data are discarded, and no `o_done` is produced.
- `i_start` in the same cycle as DONE is ignored. It must be reasserted while IDLE.

## Configuration
- `BRAM_RD_STRIDE_EN`:
  - Defined: the `i_stride` port exists, is latched on start, and sets the address increment. Stride 0 re-reads base len times.
  - Undefined: there is no port and the increment is fixed at 1.

## Structure
- Shared package `lenet_pkg`: FSM state encoding (`ST_IDLE`, `ST_RUN`, `ST_DONE`), `FIFO_DEPTH`=2, and default `ADDR_WIDTH`/`MEM_WIDTH`.
- One sub-module: `skid_fifo2`, a 2-entry synchronous FIFO with push/pop/count and async active-low reset. The top level holds the FSM, counters, and credit logic.

## Test plan
- BRAM preloaded with data[i]=i+0x100; start base=10, len=5, `i_ready`=1 → `o_data` 0x10A..0x10E on consecutive cycles. First valid comes 2 cycles after start; `o_done` pulses 1 cycle after the last beat.
- Same transfer with `i_ready` toggling at random → identical ordered sequence. `o_data` is stable while stalled; `o_ce` never fires with 2 words buffered plus inflight.
- base=4094, len=4, ADDR_WIDTH=12 → addresses 4094, 4095, 0, 1 (wrap-around).
- len=0 → no `o_ce` and no `o_valid`; `o_done` 1 cycle after start.
- `reset_n` asserted at beat 3 of len=8 → outputs reach reset values asynchronously with no `o_done`. A new start base=0, len=2 then streams data[0], data[1] correctly.
- `BRAM_RD_STRIDE_EN`, stride=3, base=0, len=4 → addresses 0, 3, 6, 9. A start pulse during RUN is ignored.
